neuron_backprop_seq: RTL and testbench

- Backward-direction companion to the learning neuron: takes a neuron's forward result (`out`), its target (`expected_out`), its inputs and weights, and produces `expected_in[i]`, the target value for each upstream input.
- The result feeds the previous layer as that layer's `expected_out`.
- Sequential engine: captures one request through a valid/ready handshake, then streams one element per cycle with backpressure, while also holding the full vector in a register.

---
 rtl/neuron_backprop_seq.sv | 209 ++++++++++++++++++++
 tb/tb_neuron_backprop_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/neuron_backprop_seq.sv
// Backward pass for one neuron: streams expected_in[i] for the previous layer.
// Optional build macro NEURON_BACKPROP_RATE_EN adds a rate_shift port that scales each adjustment down.
module neuron_backprop_seq #(
  parameter int N      = 16,
  parameter int Z_W    = 8,
  parameter int F_W    = 16,
  parameter int F_FRAC = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef NEURON_BACKPROP_RATE_EN
  input  logic [2:0]            rate_shift,
`endif
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [N-1:0][Z_W-1:0] in,
  input  logic [N-1:0][F_W-1:0] weights,
  input  logic [Z_W-1:0]        out,
  input  logic [Z_W-1:0]        expected_out,
  output logic                  ei_valid,
  input  logic                  ei_ready,
  output logic [$clog2(N)-1:0]  ei_index,
  output logic [Z_W-1:0]        ei_data,
  output logic                  ei_last,
  output logic [N-1:0][Z_W-1:0] expected_in,
  output logic                  done
);

  localparam int IDX_W = $clog2(N);
  localparam int M_W   = F_W - 1;
  localparam int P_W   = Z_W + M_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [Z_W-1:0]   Z_MAX    = {Z_W{1'b1}};

  typedef enum logic [1:0] {IDLE = 2'd0, STREAM = 2'd1, DONE = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [N-1:0][Z_W-1:0]  in_r, exp_in_r;
  logic [N-1:0][F_W-1:0]  weights_r;
  logic [Z_W:0]           delta_r, delta_in_s, d_sel_s;
  logic [2:0]             rate_r, rate_in_s, sh_sel_s;
  logic [IDX_W-1:0]       idx_r, nxt_idx_s;
  logic [Z_W-1:0]         ei_data_r, x_sel_s, elem_s;
  logic [F_W-1:0]         w_sel_s;
  logic                   req_ready_r, ei_valid_r, ei_last_r, done_r;
  logic                   accept_s, advance_s, fire_s;

  // Target for one input: nudge it by |delta|*|w| toward the side that moves out toward expected_out.
  function automatic logic [Z_W-1:0] calc_elem(input logic [Z_W-1:0] x, input logic [F_W-1:0] w,
                                               input logic [Z_W:0] d, input logic [2:0] sh);
    logic [Z_W-1:0] mag_d;
    logic [F_W-1:0] neg_w;
    logic [M_W-1:0] mag_w;
    logic [P_W-1:0] prod;
    logic [P_W-1:0] adj_wide;
    logic [Z_W-1:0] adj_z;
    logic [Z_W:0]   sum;
    logic [Z_W-1:0] res;
    neg_w = -w;
    if (d[Z_W]) begin
      mag_d = Z_W'(-d);
    end else begin
      mag_d = d[Z_W-1:0];
    end
    if (!w[F_W-1]) begin
      mag_w = w[M_W-1:0];
    end else if (neg_w[F_W-1]) begin
      mag_w = {M_W{1'b1}};
    end else begin
      mag_w = neg_w[M_W-1:0];
    end
    prod = P_W'(mag_d) * P_W'(mag_w);
    // The >>Z_W to frac units and >>(F_FRAC-Z_W) back to zero2one collapse into one truncating shift.
    adj_wide = prod >> F_FRAC;
    if (adj_wide > P_W'(Z_MAX)) begin
      adj_z = Z_MAX;
    end else begin
      adj_z = adj_wide[Z_W-1:0];
    end
    adj_z = adj_z >> sh;
    sum = {1'b0, x} + {1'b0, adj_z};
    if ((d == {(Z_W+1){1'b0}}) || (w == {F_W{1'b0}})) begin
      res = x;
    end else if (w[F_W-1] == d[Z_W]) begin
      res = sum[Z_W] ? Z_MAX : sum[Z_W-1:0];
    end else begin
      res = (adj_z > x) ? {Z_W{1'b0}} : (x - adj_z);
    end
    return res;
  endfunction

  assign delta_in_s = {1'b0, expected_out} - {1'b0, out};
`ifdef NEURON_BACKPROP_RATE_EN
  assign rate_in_s = rate_shift;
`else
  assign rate_in_s = 3'd0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    advance_s = 1'b0;
    fire_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          accept_s = 1'b1;
          state_s  = STREAM;
        end else begin
          state_s = IDLE;
        end
      end
      STREAM: begin
        if (ei_ready) begin
          fire_s = 1'b1;
          if (idx_r == LAST_IDX) begin
            state_s = DONE;
          end else begin
            advance_s = 1'b1;
            state_s   = STREAM;
          end
        end else begin
          state_s = STREAM;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // One shared arithmetic unit: fed from the ports at acceptance, from the captured copy afterwards.
  always_comb begin
    nxt_idx_s = idx_r + IDX_W'(1);
    if (state_r == IDLE) begin
      x_sel_s  = in[0];
      w_sel_s  = weights[0];
      d_sel_s  = delta_in_s;
      sh_sel_s = rate_in_s;
    end else begin
      x_sel_s  = in_r[nxt_idx_s];
      w_sel_s  = weights_r[nxt_idx_s];
      d_sel_s  = delta_r;
      sh_sel_s = rate_r;
    end
    elem_s = calc_elem(x_sel_s, w_sel_s, d_sel_s, sh_sel_s);
  end

  // Request capture, element streaming and the result vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_r        <= '0;
      weights_r   <= '0;
      delta_r     <= '0;
      rate_r      <= 3'd0;
      idx_r       <= '0;
      ei_data_r   <= '0;
      ei_last_r   <= 1'b0;
      exp_in_r    <= '0;
      req_ready_r <= 1'b1;
      ei_valid_r  <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      req_ready_r <= (state_s == IDLE);
      ei_valid_r  <= (state_s == STREAM);
      done_r      <= (state_s == DONE);
      if (accept_s) begin
        in_r      <= in;
        weights_r <= weights;
        delta_r   <= delta_in_s;
        rate_r    <= rate_in_s;
        idx_r     <= '0;
        ei_data_r <= elem_s;
        ei_last_r <= 1'b0;
      end else if (advance_s) begin
        idx_r     <= nxt_idx_s;
        ei_data_r <= elem_s;
        ei_last_r <= (nxt_idx_s == LAST_IDX);
      end else if (fire_s) begin
        ei_last_r <= 1'b0;
      end else begin
        ei_last_r <= ei_last_r;
      end
      if (fire_s) begin
        exp_in_r[idx_r] <= ei_data_r;
      end else begin
        exp_in_r <= exp_in_r;
      end
    end
  end

  assign req_ready   = req_ready_r;
  assign ei_valid    = ei_valid_r;
  assign ei_index    = idx_r;
  assign ei_data     = ei_data_r;
  assign ei_last     = ei_last_r;
  assign expected_in = exp_in_r;
  assign done        = done_r;

endmodule

// File: tb/tb_neuron_backprop_seq.sv
// Directed self-checking bench for neuron_backprop_seq; expected values are hand-computed.
module tb_neuron_backprop_seq;
  localparam int N     = 16;
  localparam int Z_W   = 8;
  localparam int F_W   = 16;
  localparam int IDX_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n, req_valid, req_ready, ei_valid, ei_ready, ei_last, done;
  logic [N-1:0][Z_W-1:0] in_v, exp_in_w;
  logic [N-1:0][F_W-1:0] weights_v;
  logic [Z_W-1:0]        out_v, exp_out_v, ei_data;
  logic [IDX_W-1:0]      ei_index;
  logic [Z_W-1:0]        exp_vec [N];
`ifdef NEURON_BACKPROP_RATE_EN
  logic [2:0]            rate_shift;
`endif
  int vec_cnt = 0;
  int err_cnt = 0;

  neuron_backprop_seq dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef NEURON_BACKPROP_RATE_EN
    .rate_shift(rate_shift),
`endif
    .req_valid(req_valid),
    .req_ready(req_ready),
    .in(in_v),
    .weights(weights_v),
    .out(out_v),
    .expected_out(exp_out_v),
    .ei_valid(ei_valid),
    .ei_ready(ei_ready),
    .ei_index(ei_index),
    .ei_data(ei_data),
    .ei_last(ei_last),
    .expected_in(exp_in_w),
    .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vec_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Default request: in[i]=10*i+5, all weights zero, so every element passes in[i] through.
  task automatic clear_req();
    for (int i = 0; i < N; i++) begin
      in_v[i]      = Z_W'(10 * i + 5);
      weights_v[i] = 16'd0;
    end
    out_v     = 8'd128;
    exp_out_v = 8'd192;
`ifdef NEURON_BACKPROP_RATE_EN
    rate_shift = 3'd0;
`endif
  endtask

  task automatic load_exp();
    for (int i = 0; i < N; i++) exp_vec[i] = in_v[i];
  endtask

  task automatic run_op(input string nm, input bit stall, input bit scramble);
    int got, cyc, ph;
    bit stalled;
    logic [IDX_W-1:0] h_idx;
    logic [Z_W-1:0] h_dat;
    got = 0; cyc = 0; ph = 0; stalled = 1'b0;
    h_idx = '0; h_dat = '0;
    chk({nm, "_rdy_idle"}, req_ready, 1);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    while (got < N && cyc < 200) begin
      if (stall) ei_ready = (ph < 2) ? 1'b0 : ((ph % 2) == 0);
      else ei_ready = 1'b1;
      ph++;
      chk({nm, "_valid"}, ei_valid, 1);
      chk({nm, "_rdy_busy"}, req_ready, 0);
      if (stalled) begin
        chk($sformatf("%s_hold_idx%0d", nm, got), ei_index, h_idx);
        chk($sformatf("%s_hold_dat%0d", nm, got), ei_data, h_dat);
      end
      if (ei_ready) begin
        chk($sformatf("%s_idx%0d", nm, got), ei_index, got);
        chk($sformatf("%s_dat%0d", nm, got), ei_data, exp_vec[got]);
        chk($sformatf("%s_last%0d", nm, got), ei_last, (got == N - 1));
        got++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        h_idx = ei_index;
        h_dat = ei_data;
      end
      if (scramble) begin
        for (int i = 0; i < N; i++) begin
          in_v[i]      = Z_W'($urandom);
          weights_v[i] = F_W'($urandom);
        end
        exp_out_v = Z_W'($urandom);
      end
      tick();
      cyc++;
    end
    ei_ready = 1'b0;
    chk({nm, "_count"}, got, N);
    if (!stall) chk({nm, "_latency"}, cyc, N);
    chk({nm, "_done_hi"}, done, 1);
    chk({nm, "_valid_off"}, ei_valid, 0);
    tick();
    chk({nm, "_done_lo"}, done, 0);
    chk({nm, "_rdy_back"}, req_ready, 1);
    for (int i = 0; i < N; i++) chk($sformatf("%s_vec%0d", nm, i), exp_in_w[i], exp_vec[i]);
  endtask

  task automatic basic_setup();
    clear_req();
    in_v[0] = 8'd100; weights_v[0] = 16'd2048;
    in_v[1] = 8'd100; weights_v[1] = 16'hF800;
    load_exp();
`ifdef NEURON_BACKPROP_RATE_EN
    rate_shift = 3'd2;
    exp_vec[0] = 8'd108; exp_vec[1] = 8'd92;
`else
    exp_vec[0] = 8'd132; exp_vec[1] = 8'd68;
`endif
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; ei_ready = 1'b0;
    clear_req();
    tick(); tick();
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ei_valid", ei_valid, 0);
    chk("rst_ei_index", ei_index, 0);
    chk("rst_ei_data", ei_data, 0);
    chk("rst_ei_last", ei_last, 0);
    chk("rst_done", done, 0);
    chk("rst_vec_zero", (exp_in_w != '0), 0);
    rst_n = 1'b1;
    tick();

    // Basic stream; weights[3]=0 with nonzero delta keeps in[3].
    basic_setup();
    run_op("basic", 1'b0, 1'b0);

    // Saturation with delta=+64.
    clear_req();
    in_v[0] = 8'd250; weights_v[0] = 16'd4096;
    in_v[1] = 8'd10;  weights_v[1] = 16'hF000;
    load_exp();
    exp_vec[0] = 8'd255; exp_vec[1] = 8'd0;
    run_op("satA", 1'b0, 1'b0);

    // delta=+255: clamped most-negative weight, max positive weight, and an unsaturated 255*2048>>12=127.
    clear_req();
    exp_out_v = 8'd255; out_v = 8'd0;
    in_v[0] = 8'd200; weights_v[0] = 16'h8000;
    in_v[1] = 8'd3;   weights_v[1] = 16'h7FFF;
    in_v[2] = 8'd100; weights_v[2] = 16'd2048;
    load_exp();
    exp_vec[0] = 8'd0; exp_vec[1] = 8'd255; exp_vec[2] = 8'd227;
    run_op("satB", 1'b0, 1'b0);

    // Zero delta: every element passes through despite nonzero weights.
    clear_req();
    exp_out_v = 8'd77; out_v = 8'd77;
    for (int i = 0; i < N; i++) begin
      in_v[i] = Z_W'(3 * i + 1);
      weights_v[i] = F_W'(16'h1000 + i);
    end
    load_exp();
    run_op("zero", 1'b0, 1'b0);

    // Backpressure with negative delta=-128 and inputs scrambled during the stream.
    clear_req();
    exp_out_v = 8'd64; out_v = 8'd192;
    in_v[0] = 8'd100; weights_v[0] = 16'hF800;
    in_v[1] = 8'd100; weights_v[1] = 16'd1024;
    in_v[2] = 8'd100; weights_v[2] = 16'd2049;
    load_exp();
    exp_vec[0] = 8'd164; exp_vec[1] = 8'd68; exp_vec[2] = 8'd36;
    run_op("bp", 1'b1, 1'b1);

    // Reset while index 5 is presented.
    basic_setup();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    ei_ready = 1'b1;
    for (int c = 0; c < 40 && ei_index != 4'd5; c++) tick();
    chk("mid_at_idx5", ei_index, 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    ei_ready = 1'b0;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_ei_valid", ei_valid, 0);
    chk("mid_done", done, 0);
    chk("mid_ei_index", ei_index, 0);
    chk("mid_vec_zero", (exp_in_w != '0), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("mid_no_done", done, 0);
      chk("mid_still_idle", ei_valid, 0);
    end

    basic_setup();
    run_op("after_rst", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
